// File: rtl/operand_stack_ctrl_pkg.sv
// Shared definitions for the operand stack controller: ALU op indices, flag
// bit positions, command and error encodings, FSM states and op helpers.
package operand_stack_ctrl_pkg;

    localparam int unsigned NumOps = 12;

    // ALU operation indices; alu_opcode bit n selects operation n.
    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpInx = 4'd2,
        OpDcx = 4'd3,
        OpCpx = 4'd4,
        OpShl = 4'd5,
        OpShr = 4'd6,
        OpSra = 4'd7,
        OpAnd = 4'd8,
        OpOr  = 4'd9,
        OpXor = 4'd10,
        OpNot = 4'd11
    } alu_op_e;

    // Bit positions inside the 4-bit ALU flag vector {CF,OF,SF,ZF}.
    localparam int unsigned FlagZf = 0;
    localparam int unsigned FlagSf = 1;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagCf = 3;

    typedef enum logic [1:0] {
        CmdPush = 2'd0,
        CmdPop  = 2'd1,
        CmdExec = 2'd2,
        CmdNop  = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ErrNone      = 2'd0,
        ErrOverflow  = 2'd1,
        ErrUnderflow = 2'd2,
        ErrIllegalOp = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StWb   = 2'd2
    } state_e;

    // Operation index within the legal range 0..NumOps-1.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op < 4'(NumOps);
    endfunction

    // Single-operand operations consume only the top entry.
    function automatic logic is_unary(input logic [3:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OpInx, OpDcx, OpCpx, OpShl, OpShr, OpSra, OpNot: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // One-hot ALU opcode for a legal op index; all-zero for anything else.
    function automatic logic [NumOps-1:0] op_onehot(input logic [3:0] op);
        logic [NumOps-1:0] oh;
        oh = '0;
        if (is_legal_op(op)) begin
            oh[op] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/operand_stack_mem.sv
// Register-array operand stack with top/second read ports, push, pop and an
// in-place result replace that optionally collapses two operands into one.
module operand_stack_mem
    import operand_stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_en,
    input  logic                     repl_en,
    input  logic                     repl_bin,
    input  logic [W-1:0]             repl_data,
    output logic [W-1:0]             top,
    output logic [W-1:0]             second,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] sec_idx;
    logic [DW-1:0] top_pos;
    logic [DW-1:0] sec_pos;

    // Entry indices derived from the occupancy count; wrap is harmless
    // because reads are masked when the entry does not exist.
    always_comb begin
        top_pos  = depth_q - DW'(1);
        sec_pos  = depth_q - DW'(2);
        push_idx = depth_q[AW-1:0];
        top_idx  = top_pos[AW-1:0];
        sec_idx  = sec_pos[AW-1:0];
    end

    // Read ports return zero for entries that are not occupied.
    always_comb begin
        top    = (depth_q != '0)       ? mem_q[top_idx] : '0;
        second = (depth_q >= DW'(2))   ? mem_q[sec_idx] : '0;
        depth  = depth_q;
    end

    // Storage and occupancy update; the controller issues at most one op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            depth_q <= '0;
        end else if (push_en) begin
            mem_q[push_idx] <= push_data;
            depth_q         <= depth_q + DW'(1);
        end else if (pop_en) begin
            depth_q <= depth_q - DW'(1);
        end else if (repl_en) begin
            if (repl_bin) begin
                mem_q[sec_idx] <= repl_data;
                depth_q        <= depth_q - DW'(1);
            end else begin
                mem_q[top_idx] <= repl_data;
            end
        end
    end

endmodule

// File: rtl/operand_stack_ctrl.sv
// Operand stack controller: accepts PUSH/POP/EXEC/NOP commands, feeds stack
// operands to an external combinational ALU and writes the result back.
module operand_stack_ctrl
    import operand_stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [3:0]               cmd_op,
    input  logic [W-1:0]             cmd_data,
    output logic [W-1:0]             alu_x,
    output logic [W-1:0]             alu_y,
    output logic [NumOps-1:0]        alu_opcode,
    input  logic [W-1:0]             alu_z,
    input  logic [3:0]               alu_flags,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic [3:0]               flags,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int unsigned DW = $clog2(DEPTH) + 1;

    state_e            state_q;
    logic [W-1:0]      alu_x_q;
    logic [W-1:0]      alu_y_q;
    logic [NumOps-1:0] alu_op_q;
    logic [W-1:0]      z_q;
    logic [3:0]        flags_cap_q;
    logic [3:0]        flags_q;
    logic              bin_q;
    logic              err_q;
    err_code_e         err_code_q;

    cmd_type_e         ctype;
    logic              accept;
    logic              push_ok;
    logic              pop_ok;
    logic              exec_ok;
    logic              reject;
    err_code_e         reject_code;
    logic              unary;
    logic [W-1:0]      stk_top;
    logic [W-1:0]      stk_second;
    logic [DW-1:0]     stk_depth;

    assign ctype     = cmd_type_e'(cmd_type);
    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid & cmd_ready;
    assign unary     = is_unary(cmd_op);

    // Classify an accepted command; rejected ones leave the stack untouched.
    always_comb begin
        push_ok     = 1'b0;
        pop_ok      = 1'b0;
        exec_ok     = 1'b0;
        reject      = 1'b0;
        reject_code = ErrNone;
        if (accept) begin
            case (ctype)
                CmdPush: begin
                    if (stk_depth == DW'(DEPTH)) begin
                        reject      = 1'b1;
                        reject_code = ErrOverflow;
                    end else begin
                        push_ok = 1'b1;
                    end
                end
                CmdPop: begin
                    if (stk_depth == '0) begin
                        reject      = 1'b1;
                        reject_code = ErrUnderflow;
                    end else begin
                        pop_ok = 1'b1;
                    end
                end
                CmdExec: begin
                    // Illegal op is reported even when operands are also missing.
                    if (!is_legal_op(cmd_op)) begin
                        reject      = 1'b1;
                        reject_code = ErrIllegalOp;
                    end else if (stk_depth < (unary ? DW'(1) : DW'(2))) begin
                        reject      = 1'b1;
                        reject_code = ErrUnderflow;
                    end else begin
                        exec_ok = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered ALU drive, result capture and error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_op_q    <= '0;
            z_q         <= '0;
            flags_cap_q <= '0;
            flags_q     <= '0;
            bin_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ErrNone;
        end else begin
            err_q <= reject;
            if (reject) begin
                err_code_q <= reject_code;
            end
            case (state_q)
                StIdle: begin
                    if (exec_ok) begin
                        state_q  <= StExec;
                        alu_op_q <= op_onehot(cmd_op);
                        bin_q    <= !unary;
                        if (unary) begin
                            alu_x_q <= stk_top;
                            alu_y_q <= '0;
                        end else begin
                            alu_x_q <= stk_second;
                            alu_y_q <= stk_top;
                        end
                    end
                end
                StExec: begin
                    // ALU output is valid while operands are driven; latch it here.
                    state_q     <= StWb;
                    z_q         <= alu_z;
                    flags_cap_q <= alu_flags;
                    alu_x_q     <= '0;
                    alu_y_q     <= '0;
                    alu_op_q    <= '0;
                end
                StWb: begin
                    state_q <= StIdle;
                    flags_q <= flags_cap_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    operand_stack_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_ok),
        .push_data (cmd_data),
        .pop_en    (pop_ok),
        .repl_en   (state_q == StWb),
        .repl_bin  (bin_q),
        .repl_data (z_q),
        .top       (stk_top),
        .second    (stk_second),
        .depth     (stk_depth)
    );

    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_opcode = alu_op_q;
    assign top        = stk_top;
    assign depth      = stk_depth;
    assign flags      = flags_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: doc/operand_stack_ctrl.md
OPERAND_STACK_CTRL -- requirements
Module: operand_stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of 32-bit operand stack entries (power of two, 2..16).
REQ-002 Parameter W, default 32, datapath width, matching the ALU x/y/z width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  controller can accept a command this cycle.
REQ-007 cmd_type  input  2  0=PUSH, 1=POP, 2=EXEC, 3=NOP.
REQ-008 cmd_op  input  4  ALU operation index 0..11 (ADD,SUB,INX,DCX,CPX,SHL,SHR,SRA,AND,OR,XOR,NOT); used only for EXEC.
REQ-009 cmd_data  input  W  value for PUSH.
REQ-010 alu_x, alu_y  output  W  operands to the ALU.
REQ-011 alu_opcode  output  12  one-hot ALU opcode; bit n = operation index n.
REQ-012 alu_z  input  W  ALU result.
REQ-013 alu_flags  input  4  ALU flags {CF,OF,SF,ZF} at bits 3..0.
REQ-014 top  output  W  current top-of-stack entry; 0 when empty.
REQ-015 depth  output  $clog2(DEPTH)+1  occupied entries.
REQ-016 flags  output  4  flags captured by the last completed EXEC.
REQ-017 err  output  1  one-cycle pulse on a rejected command.
REQ-018 err_code  output  2  1=overflow, 2=underflow, 3=illegal op; held until the next err pulse.

Function
REQ-019 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high only in state IDLE.
REQ-020 FSM states IDLE, EXEC, WB; IDLE->EXEC on an accepted legal EXEC, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-021 PUSH SHALL complete on the accept edge: entry[depth]=cmd_data, depth+1.
REQ-022 POP SHALL complete on the accept edge: depth-1; the popped value is discarded.
REQ-023 NOP SHALL be accepted with no state change.
REQ-024 Binary ops (ADD,SUB,AND,OR,XOR) SHALL need depth>=2, with alu_x=second entry and alu_y=top.
REQ-025 Unary ops (INX,DCX,CPX,SHL,SHR,SRA,NOT) SHALL need depth>=1, with alu_x=top and alu_y=0.
REQ-026 In state EXEC, registered alu_x, alu_y and alu_opcode SHALL be driven for exactly one cycle; alu_opcode SHALL be all-zero in every other state.
REQ-027 In WB, alu_z SHALL be sampled from the EXEC cycle's combinational result registered at the EXEC->WB edge, together with alu_flags.
REQ-028 On the WB->IDLE edge, the operands SHALL be replaced by the result (binary: depth-1; unary: depth unchanged), and flags SHALL be updated.
REQ-029 EXEC latency SHALL be 3 edges from accept to result visible on top; cmd_ready SHALL rise in the cycle after WB.
REQ-030 PUSH at depth==DEPTH SHALL assert err with code 1 and leave the stack unchanged.
REQ-031 POP at depth 0, or EXEC with too few operands, SHALL assert err with code 2, leave the stack unchanged and generate no ALU activity.
REQ-032 EXEC with cmd_op>11 SHALL assert err with code 3 and leave the stack unchanged; illegal-op checking SHALL take priority over underflow checking.
REQ-033 Rejected commands SHALL still be accepted (cmd_ready handshake completes) and the FSM SHALL stay in IDLE.
REQ-034 cmd_op and cmd_data SHALL be ignored for non-EXEC and non-PUSH commands respectively.

Reset
REQ-035 rst SHALL force, immediately and regardless of clk: state IDLE, depth 0, all entries 0, top 0, flags 0, alu_x/alu_y/alu_opcode 0, err 0, err_code 0, cmd_ready 1 after release.
REQ-036 rst asserted during EXEC or WB SHALL abort the operation with no writeback.

Structure
REQ-037 A shared package SHALL hold the op indices 0..11, the flag bit positions ZF=0/SF=1/OF=2/CF=3, the cmd_type encodings, the err_code values, the FSM state enum, and an is_unary lookup.
REQ-038 Stack storage SHALL be a separate sub-module, operand_stack_mem, providing a register array, top and second read ports, and write/replace with depth tracking.

Verification
REQ-039 PUSH 0x90000180, PUSH 0x04000140, EXEC ADD -> alu_opcode=0x001 for one cycle, then top=0x940002C0 and depth=1.
REQ-040 Same two pushes, then EXEC SUB -> alu_x=0x90000180, alu_y=0x04000140, top=0x8C000040, depth=1.
REQ-041 PUSH 5, EXEC INX -> alu_opcode=0x004, alu_y=0, depth stays 1, top=ALU result.
REQ-042 DEPTH pushes followed by one further PUSH -> err pulse, err_code=1, depth=DEPTH, top unchanged; POP at empty -> err_code=2.
REQ-043 PUSH 1, EXEC AND -> err_code=2 with alu_opcode staying 0; EXEC with cmd_op=12 -> err_code=3.
REQ-044 Assert rst in the EXEC cycle -> depth=0, alu_opcode=0 immediately, no writeback, cmd_ready=1 after release.
